// File: rtl/mem_burst_agen.sv
// ---------------------------------------------------------------------------
// mem_burst_agen
//   Burst address/data generator feeding a memory's addr/data ports.
//   One command is accepted in IDLE; it then emits cmd_len+1 beats with
//   incrementing (wrapping) addresses and either constant or incrementing
//   (wrapping) data, one beat per mem_valid/mem_ready handshake.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (cmd_ready decoded from IDLE)
//   cmd_addr, cmd_len       start address, beats minus one
//   cmd_seed, cmd_incr      first data value, data increments when 1
//   abort                   end the current burst early (BURST only)
//   mem_valid / mem_ready   beat handshake towards the memory
//   mem_addr, mem_data      beat address and data
//   busy                    high while in BURST or DONE
//   done, aborted           one-cycle end-of-burst pulse, early-end flag
//   beat_cnt                beats transferred in current/last burst
// ---------------------------------------------------------------------------
module mem_burst_agen #(
    parameter int addr_width = 16,
    parameter int data_width = 8,
    parameter int len_width  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [addr_width-1:0] cmd_addr,
    input  logic [len_width-1:0]  cmd_len,
    input  logic [data_width-1:0] cmd_seed,
    input  logic                  cmd_incr,
    input  logic                  abort,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [len_width:0]    beat_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [addr_width-1:0] ADDR_ONE  = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [data_width-1:0] DATA_ONE  = {{(data_width-1){1'b0}}, 1'b1};
    localparam logic [len_width-1:0]  LEN_ONE   = {{(len_width-1){1'b0}}, 1'b1};
    localparam logic [len_width-1:0]  LEN_ZERO  = {len_width{1'b0}};
    localparam logic [len_width:0]    CNT_ONE   = {{len_width{1'b0}}, 1'b1};
    localparam logic [len_width:0]    CNT_ZERO  = {(len_width+1){1'b0}};

    state_e                state_q,     state_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [addr_width-1:0] mem_addr_q,  mem_addr_d;
    logic [data_width-1:0] mem_data_q,  mem_data_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;
    logic                  aborted_q,   aborted_d;
    logic [len_width:0]    beat_cnt_q,  beat_cnt_d;
    logic [len_width-1:0]  remaining_q, remaining_d;
    logic                  incr_q,      incr_d;
    logic                  handshake_s;

    assign handshake_s = mem_valid_q && mem_ready;
    assign cmd_ready   = (state_q == ST_IDLE);

    // Next-state and next-output computation for the burst FSM.
    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        aborted_d   = aborted_q;
        beat_cnt_d  = beat_cnt_q;
        remaining_d = remaining_q;
        incr_d      = incr_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    mem_addr_d  = cmd_addr;
                    mem_data_d  = cmd_seed;
                    remaining_d = cmd_len;
                    incr_d      = cmd_incr;
                    beat_cnt_d  = CNT_ZERO;
                    mem_valid_d = 1'b1;
                    state_d     = ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (handshake_s) begin
                    // The accepted beat always counts, even when aborting.
                    beat_cnt_d = beat_cnt_q + CNT_ONE;
                    if (remaining_q == LEN_ZERO) begin
                        mem_valid_d = 1'b0;
                        aborted_d   = 1'b0;
                        state_d     = ST_DONE;
                    end else if (abort) begin
                        mem_valid_d = 1'b0;
                        aborted_d   = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        mem_addr_d  = mem_addr_q + ADDR_ONE;
                        mem_data_d  = incr_q ? (mem_data_q + DATA_ONE) : mem_data_q;
                        remaining_d = remaining_q - LEN_ONE;
                    end
                end else if (abort) begin
                    mem_valid_d = 1'b0;
                    aborted_d   = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                mem_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // Status flags are registered from the state being entered.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= {addr_width{1'b0}};
            mem_data_q  <= {data_width{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            beat_cnt_q  <= CNT_ZERO;
            remaining_q <= LEN_ZERO;
            incr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            beat_cnt_q  <= beat_cnt_d;
            remaining_q <= remaining_d;
            incr_q      <= incr_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_mem_burst_agen.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_agen
//   Self-checking bench for mem_burst_agen (default parameters 16/8/8).
//   Expected beats are computed arithmetically from the command
//   (addr = start + i, data = seed + i or seed), with directed scenarios
//   followed by randomized commands, backpressure and aborts.
// ---------------------------------------------------------------------------
module tb_mem_burst_agen;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [7:0]  cmd_seed;
    logic        cmd_incr;
    logic        abort;
    logic        mem_valid;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [8:0]  beat_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    mem_burst_agen #(.addr_width(16), .data_width(8), .len_width(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_seed  (cmd_seed),
        .cmd_incr  (cmd_incr),
        .abort     (abort),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .beat_cnt  (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"},   32'(mem_valid), 32'd0);
        check_eq({tag, "_addr"},    32'(mem_addr),  32'd0);
        check_eq({tag, "_data"},    32'(mem_data),  32'd0);
        check_eq({tag, "_busy"},    32'(busy),      32'd0);
        check_eq({tag, "_done"},    32'(done),      32'd0);
        check_eq({tag, "_aborted"}, 32'(aborted),   32'd0);
        check_eq({tag, "_cnt"},     32'(beat_cnt),  32'd0);
    endtask

    // rmode: 0 ready always, 1 pattern 1,0,0 repeating, 2 random.
    // ab_beat < 0: no abort. ab_hs=1: abort with handshake number ab_beat
    // (1-based). ab_hs=0: abort without handshake after ab_beat beats.
    task automatic run_cmd(input logic [15:0] a, input logic [7:0] len,
                           input logic [7:0] seed, input logic inc,
                           input int rmode, input int ab_beat, input logic ab_hs);
        int   total;
        int   n;
        int   cyc;
        bit   fin;
        int   exp_cnt;
        logic exp_ab;
        logic rdy;
        logic ab;
        logic [15:0] ea;
        logic [7:0]  ed;
        total = int'(len) + 1;
        n = 0;
        cyc = 0;
        fin = 1'b0;
        if (ab_beat < 0) begin
            exp_cnt = total;
            exp_ab  = 1'b0;
        end else if (ab_hs) begin
            exp_cnt = ab_beat;
            exp_ab  = (ab_beat < total);
        end else begin
            exp_cnt = ab_beat;
            exp_ab  = 1'b1;
        end

        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_incr  = inc;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = 16'($urandom);
        cmd_seed  = 8'($urandom);

        while (!fin && cyc < 4000) begin
            ea = a + 16'(n);
            ed = inc ? (seed + 8'(n)) : seed;
            check_eq("beat_valid", 32'(mem_valid), 32'd1);
            check_eq("beat_addr",  32'(mem_addr),  32'(ea));
            check_eq("beat_data",  32'(mem_data),  32'(ed));
            check_eq("burst_busy", 32'(busy),      32'd1);
            check_eq("burst_done", 32'(done),      32'd0);
            check_eq("burst_rdy",  32'(cmd_ready), 32'd0);
            check_eq("burst_cnt",  32'(beat_cnt),  32'(n));
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 3) == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ab = 1'b0;
            if (ab_beat >= 0 && !ab_hs && n == ab_beat) begin
                rdy = 1'b0;
                ab  = 1'b1;
                fin = 1'b1;
            end
            if (ab_beat >= 0 && ab_hs && n + 1 == ab_beat) begin
                rdy = 1'b1;
                ab  = 1'b1;
            end
            if (rdy) begin
                n++;
                if (n == total || ab) fin = 1'b1;
            end
            mem_ready = rdy;
            abort     = ab;
            // Keep a hold-off abort flag from leaking into the next command.
            @(negedge clk);
            cyc++;
        end
        check_eq("burst_beats", 32'(n), 32'(exp_cnt));

        // DONE cycle: mem_ready/abort are don't-care and must be ignored.
        mem_ready = 1'($urandom_range(0, 1));
        abort     = 1'($urandom_range(0, 1));
        check_eq("done_pulse",   32'(done),      32'd1);
        check_eq("done_busy",    32'(busy),      32'd1);
        check_eq("done_valid",   32'(mem_valid), 32'd0);
        check_eq("done_cmd_rdy", 32'(cmd_ready), 32'd0);
        check_eq("done_cnt",     32'(beat_cnt),  32'(exp_cnt));
        check_eq("done_aborted", 32'(aborted),   32'(exp_ab));
        @(negedge clk);
        abort     = 1'b0;
        mem_ready = 1'b0;
        check_eq("idle_done",    32'(done),      32'd0);
        check_eq("idle_busy",    32'(busy),      32'd0);
        check_eq("idle_valid",   32'(mem_valid), 32'd0);
        check_eq("idle_cmd_rdy", 32'(cmd_ready), 32'd1);
        check_eq("hold_cnt",     32'(beat_cnt),  32'(exp_cnt));
        check_eq("hold_aborted", 32'(aborted),   32'(exp_ab));
    endtask

    initial begin
        int ln;
        int ab_sel;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = 16'd0;
        cmd_len   = 8'd0;
        cmd_seed  = 8'd0;
        cmd_incr  = 1'b0;
        abort     = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset_cmd_rdy", 32'(cmd_ready), 32'd1);
        check_reset_outputs("post_reset");

        // Abort and mem_ready in IDLE are ignored.
        abort     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        mem_ready = 1'b0;
        check_eq("idle_abort_rdy",  32'(cmd_ready), 32'd1);
        check_eq("idle_abort_busy", 32'(busy),      32'd0);
        check_eq("idle_abort_ab",   32'(aborted),   32'd0);

        // Directed scenarios.
        run_cmd(16'h0010, 8'd3,   8'hA0, 1'b1, 0, -1, 1'b0);  // basic
        run_cmd(16'h0010, 8'd3,   8'hA0, 1'b1, 1, -1, 1'b0);  // backpressure
        run_cmd(16'hFFFE, 8'd3,   8'hFF, 1'b1, 0, -1, 1'b0);  // wrap
        run_cmd(16'h1234, 8'd255, 8'h5A, 1'b0, 0, -1, 1'b0);  // max length
        run_cmd(16'h0200, 8'd9,   8'h10, 1'b1, 0, 3,  1'b1);  // abort on 3rd
        run_cmd(16'h0300, 8'd9,   8'h20, 1'b1, 0, 10, 1'b1);  // abort on last
        run_cmd(16'h0400, 8'd9,   8'h30, 1'b1, 1, 4,  1'b0);  // abort, no hs
        run_cmd(16'h0500, 8'd0,   8'h77, 1'b1, 2, -1, 1'b0);  // single beat

        // Reset mid-burst after the 2nd beat.
        cmd_valid = 1'b1;
        cmd_addr  = 16'h0100;
        cmd_len   = 8'd9;
        cmd_seed  = 8'h40;
        cmd_incr  = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        check_eq("pre_rst_cnt", 32'(beat_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        check_reset_outputs("mid_rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_release_done", 32'(done),      32'd0);
        check_eq("rst_release_rdy",  32'(cmd_ready), 32'd1);
        run_cmd(16'h0600, 8'd4, 8'hC0, 1'b1, 2, -1, 1'b0);

        // Randomized commands.
        for (int k = 0; k < 25; k++) begin
            ln     = $urandom_range(0, 20);
            ab_sel = $urandom_range(0, 3);
            if (ab_sel == 0)
                run_cmd(16'($urandom_range(16'hFFF0, 16'hFFFF)), 8'(ln), 8'($urandom),
                        1'($urandom), 2, -1, 1'b0);
            else if (ab_sel == 1)
                run_cmd(16'($urandom), 8'(ln), 8'($urandom), 1'($urandom), 2,
                        $urandom_range(1, ln + 1), 1'b1);
            else if (ab_sel == 2)
                run_cmd(16'($urandom), 8'(ln), 8'($urandom), 1'($urandom), 2,
                        $urandom_range(0, ln), 1'b0);
            else
                run_cmd(16'($urandom), 8'(ln), 8'($urandom), 1'($urandom), 2,
                        -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
